mux_8_1_rr_sched: RTL and testbench
===================================

// Module: mux_8_1_rr_sched
// PURPOSE
//   Round-robin scheduler that shares one 8:1 mux output channel between 8 requesters.
//   Arbitrates req[7:0], drives the registered 3-bit mux select and the one-hot grant,
//   and presents the selected input on a valid/ready output with bounded bursts.
//   Sits in front of the fabric-mapped mux_8_1 datapath and sequences its select lines.
// PARAMETERS
//   DATA_W     1   width of each mux data input and of out_data
//   MAX_BURST  4   max accepted beats per grant before forced rotation; legal 1..255
// PORTS
//   clk           in   1          single clock, all state on rising edge
//   global_reset  in   1          synchronous, active-high reset
//   req           in   8          request per input, bit i = input i
//   din           in   8*DATA_W   mux data inputs, input i at din[i*DATA_W +: DATA_W]
//   out_ready     in   1          downstream accepts a beat when out_valid & out_ready
//   out_valid     out  1          busy & req[sel]
//   out_data      out  DATA_W     din[sel], combinational through mux from registered sel
//   sel           out  3          registered mux select, stable for the whole grant
//   grant         out  8          registered one-hot grant, 0 when idle
//   busy          out  1          1 in state BUSY
// BEHAVIOUR
//   - Reset (global_reset=1 at edge): state=IDLE, ptr=0, sel=0, grant=0, beat=0, busy=0;
//     out_valid=0. Overrides everything; an in-flight beat is dropped, no partial state.
//   - Arbitration: first set bit of req scanning ptr, ptr+1, ..., ptr+7 (mod 8).
//   - IDLE: if req!=0 at edge k -> BUSY after edge k; sel=winner, grant=1<<winner, beat=0.
//     Latency req->grant is one cycle. If req==0, stay IDLE.
//   - BUSY: transfer = out_valid & out_ready; beat increments on transfer only.
//     Counter width $clog2(MAX_BURST+1).
//   - Release condition at an edge in BUSY:
//     (a) transfer && beat==MAX_BURST-1, or
//     (b) req[sel]==0, i.e. requester dropped; no transfer that cycle.
//   - On release: ptr=sel+1 (7 wraps to 0). Arbitrate the same cycle with the new ptr,
//     so the current requester has lowest priority. Any hit -> new grant next cycle with
//     no idle bubble, beat=0. No hit -> IDLE, grant=0.
//   - Sole requester is re-granted back-to-back (same sel); beats continue without gap.
//   - out_ready=0: sel, grant, beat hold; out_data still tracks din[sel] live.
//   - req changes on non-granted inputs never affect the current grant.
//   - Exactly one grant bit set in BUSY; grant==0 <=> IDLE.
//   - out_data undefined-by-contract when out_valid=0, but must still equal din[sel].
// TESTING
//   1. Reset, req=8'h01, out_ready=1, MAX_BURST=4 -> grant=8'h01 one cycle later, sel=0,
//      out_valid continuous (re-grant, no bubble), beat wraps 0..3.
//   2. req=8'hFF, out_ready=1 -> grant 01,02,04,...,80,01 each held 4 transfers;
//      sel 0..7 then wraps to 0.
//   3. DATA_W=1, din=8'b10101010, single req per sel 0..7 -> out_data = 0,1,0,1,0,1,0,1.
//   4. Mid-burst out_ready=0 for 3 cycles -> sel/grant/beat unchanged, no transfer counted;
//      burst completes after out_ready returns, total 4 accepted beats.
//   5. Granted req[3] drops after 2 beats with req[5]=1 -> out_valid=0 that cycle;
//      grant=8'h20 next cycle, ptr=4.
//   6. global_reset=1 mid-burst (sel=6) -> next edge grant=0, out_valid=0, busy=0;
//      then req=8'h41 -> grant=8'h01 (ptr reset to 0).

Source files
------------

// File: rtl/mux_8_1_rr_sched_if.sv
// Handshake and data bundle between the round-robin scheduler and its requesters/downstream.
// The master side is the scheduler; the slave side is the environment that drives requests.
interface mux_8_1_rr_sched_if #(
    parameter int unsigned DATA_W = 1
);
    logic [7:0]          req;
    logic [8*DATA_W-1:0] din;
    logic                out_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [2:0]          sel;
    logic [7:0]          grant;
    logic                busy;

    modport master (
        input  req,
        input  din,
        input  out_ready,
        output out_valid,
        output out_data,
        output sel,
        output grant,
        output busy
    );

    modport slave (
        output req,
        output din,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  sel,
        input  grant,
        input  busy
    );
endinterface

// File: rtl/mux_8_1_rr_sched.sv
// Round-robin scheduler sharing one 8:1 mux output between 8 requesters, with bounded
// bursts per grant and a registered select/grant that is stable for the whole grant.
module mux_8_1_rr_sched #(
    parameter int unsigned DATA_W    = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                global_reset,
    mux_8_1_rr_sched_if.master  bus_io
);

    localparam int unsigned BeatW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q;
    logic [2:0]       ptr_q;
    logic [2:0]       sel_q;
    logic [7:0]       grant_q;
    logic [BeatW-1:0] beat_q;

    logic [2:0] arb_ptr;
    logic [2:0] arb_idx;
    logic [2:0] win;
    logic       hit;
    logic       out_valid;
    logic       xfer;
    logic       last_beat;
    logic       release_now;

    // On release the search starts just past the current owner, so it ranks last.
    always_comb begin
        arb_ptr = (state_q == StBusy) ? sel_q + 3'd1 : ptr_q;
        arb_idx = 3'd0;
        hit     = 1'b0;
        win     = 3'd0;
        for (int unsigned i = 0; i < 8; i++) begin
            arb_idx = arb_ptr + 3'(i);
            if (!hit && bus_io.req[arb_idx]) begin
                hit = 1'b1;
                win = arb_idx;
            end
        end
    end

    always_comb begin
        out_valid   = (state_q == StBusy) && bus_io.req[sel_q];
        xfer        = out_valid && bus_io.out_ready;
        last_beat   = (beat_q == BeatW'(MAX_BURST - 1));
        release_now = (xfer && last_beat) || !bus_io.req[sel_q];
    end

    always_ff @(posedge clk) begin
        if (global_reset) begin
            state_q <= StIdle;
            ptr_q   <= 3'd0;
            sel_q   <= 3'd0;
            grant_q <= 8'd0;
            beat_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hit) begin
                        state_q <= StBusy;
                        sel_q   <= win;
                        grant_q <= 8'd1 << win;
                        beat_q  <= '0;
                    end
                end
                StBusy: begin
                    if (release_now) begin
                        ptr_q  <= sel_q + 3'd1;
                        beat_q <= '0;
                        if (hit) begin
                            sel_q   <= win;
                            grant_q <= 8'd1 << win;
                        end else begin
                            state_q <= StIdle;
                            grant_q <= 8'd0;
                        end
                    end else if (xfer) begin
                        beat_q <= beat_q + BeatW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= 8'd0;
                end
            endcase
        end
    end

    assign bus_io.out_valid = out_valid;
    assign bus_io.out_data  = bus_io.din[sel_q*DATA_W +: DATA_W];
    assign bus_io.sel       = sel_q;
    assign bus_io.grant     = grant_q;
    assign bus_io.busy      = (state_q == StBusy);

endmodule

// File: tb/tb_mux_8_1_rr_sched.sv
// Bench for mux_8_1_rr_sched: directed scenarios plus random traffic, checked each cycle
// against a transaction-level round-robin model.
module tb_mux_8_1_rr_sched;

    localparam int unsigned DATA_W    = 1;
    localparam int unsigned MAX_BURST = 4;

    logic clk = 1'b0;
    logic global_reset;

    mux_8_1_rr_sched_if #(.DATA_W(DATA_W)) bus ();

    mux_8_1_rr_sched #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .global_reset (global_reset),
        .bus_io       (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: who owns the channel, where the next search starts, beats taken so far.
    bit m_busy;
    int m_owner;
    int m_next;
    int m_beats;

    function automatic int rr_pick(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  w;
        bit  valid;
        bit  xfer;
        if (global_reset) begin
            m_busy = 0; m_owner = 0; m_next = 0; m_beats = 0;
        end else if (!m_busy) begin
            w = rr_pick(bus.req, m_next);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_beats = 0;
            end
        end else begin
            valid = bus.req[m_owner];
            xfer  = valid && bus.out_ready;
            if (!valid || (xfer && m_beats + 1 == MAX_BURST)) begin
                m_next  = (m_owner + 1) % 8;
                m_beats = 0;
                w = rr_pick(bus.req, m_next);
                if (w >= 0) m_owner = w;
                else        m_busy  = 0;
            end else if (xfer) begin
                m_beats++;
            end
        end
    endtask

    task automatic step();
        logic [7:0] eg;
        @(negedge clk);
        eg = m_busy ? (8'd1 << m_owner) : 8'd0;
        check("grant", bus.grant, eg);
        check("busy", {7'd0, bus.busy}, {7'd0, m_busy});
        check("out_valid", {7'd0, bus.out_valid}, {7'd0, m_busy && bus.req[m_owner]});
        if (m_busy) check("sel", {5'd0, bus.sel}, 8'(m_owner));
        check("out_data", 8'(bus.out_data), 8'(bus.din[bus.sel*DATA_W +: DATA_W]));
        if (m_busy) check("out_data_owner", 8'(bus.out_data), 8'(bus.din[m_owner]));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        global_reset = 1'b1;
        steps(2);
        global_reset = 1'b0;
    endtask

    initial begin
        global_reset  = 1'b1;
        bus.req       = 8'h00;
        bus.din       = 8'h00;
        bus.out_ready = 1'b0;
        m_busy = 0; m_owner = 0; m_next = 0; m_beats = 0;
        #1;
        do_reset();

        // Sole requester: back-to-back re-grant, no bubble.
        bus.req = 8'h01; bus.out_ready = 1'b1; bus.din = 8'h5a;
        step();
        check("first_grant", bus.grant, 8'h01);
        steps(12);

        // Everyone requests: rotation 01,02,...,80,01.
        bus.req = 8'hff;
        steps(40);

        // Single requester per select, checking the mux path.
        do_reset();
        bus.din = 8'b10101010;
        for (int s = 0; s < 8; s++) begin
            bus.req = 8'd1 << s;
            steps(3);
            check("mux_bit", 8'(bus.out_data), 8'(s % 2));
        end

        // Backpressure mid-burst.
        do_reset();
        bus.req = 8'h04; bus.din = 8'h0f;
        steps(3);
        bus.out_ready = 1'b0;
        steps(3);
        bus.out_ready = 1'b1;
        steps(6);

        // Granted requester drops out mid-burst.
        do_reset();
        bus.req = 8'h08;
        steps(3);
        bus.req = 8'h20;
        steps(2);
        check("drop_regrant", bus.grant, 8'h20);
        bus.req = 8'h31;
        steps(8);

        // Reset mid-burst restores pointer to 0.
        do_reset();
        bus.req = 8'h40;
        steps(3);
        global_reset = 1'b1;
        step();
        global_reset = 1'b0;
        check("rst_grant", bus.grant, 8'h00);
        check("rst_busy", {7'd0, bus.busy}, 8'h00);
        bus.req = 8'h41;
        step();
        check("rst_ptr", bus.grant, 8'h01);
        steps(4);

        // Random traffic with held requests, backpressure and rare resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom);
            bus.din       = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            global_reset  = ($urandom_range(0, 149) == 0);
            step();
        end
        global_reset = 1'b0;
        steps(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
